// File: rtl/csel_pkg.sv
// -----------------------------------------------------------------------------
// csel_pkg
// Shared definitions for the pipelined carry-select subtractor:
//   - default operand and slice widths plus derived half/slice counts
//   - result bundle {diff, bout, ovf, zero}
//   - signed-overflow helper for a - b style subtraction
// No ports (package).
// -----------------------------------------------------------------------------
package csel_pkg;

  localparam int CSEL_WIDTH  = 64;
  localparam int CSEL_BLOCK  = 8;
  localparam int CSEL_HALF   = CSEL_WIDTH / 2;
  localparam int CSEL_NSLICE = CSEL_HALF / CSEL_BLOCK;

  typedef struct packed {
    logic [CSEL_WIDTH-1:0] diff;
    logic                  bout;
    logic                  ovf;
    logic                  zero;
  } csel_result_t;

  // Overflow of a - b: operands of differing sign and a result whose sign
  // differs from the minuend.
  function automatic logic csel_sub_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/csel_sub_slice.sv
// -----------------------------------------------------------------------------
// csel_sub_slice
// One carry-select slice of the subtractor datapath. Adds a_i to the already
// inverted subtrahend nb_i for both possible carry-ins and selects with cin_i.
// Ports:
//   a_i     [BLOCK]  minuend bits of this slice
//   nb_i    [BLOCK]  inverted subtrahend bits of this slice
//   cin_i   1        carry-in used for the muxed outputs
//   sum0_o  [BLOCK]  candidate sum, carry-in 0
//   sum1_o  [BLOCK]  candidate sum, carry-in 1
//   cout0_o 1        candidate carry-out, carry-in 0
//   cout1_o 1        candidate carry-out, carry-in 1
//   sum_o   [BLOCK]  sum selected by cin_i
//   cout_o  1        carry-out selected by cin_i
// -----------------------------------------------------------------------------
module csel_sub_slice
  import csel_pkg::*;
#(
  parameter int BLOCK = CSEL_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] nb_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum0_o,
  output logic [BLOCK-1:0] sum1_o,
  output logic             cout0_o,
  output logic             cout1_o,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o
);

  assign {cout0_o, sum0_o} = {1'b0, a_i} + {1'b0, nb_i};
  assign {cout1_o, sum1_o} = {1'b0, a_i} + {1'b0, nb_i} + {{BLOCK{1'b0}}, 1'b1};

  assign sum_o  = cin_i ? sum1_o  : sum0_o;
  assign cout_o = cin_i ? cout1_o : cout0_o;

endmodule

// File: rtl/csel_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// csel_subtractor_pipe
// Two-stage pipelined carry-select subtractor: diff = a - b - bin, computed
// as a + ~b + ~bin. Stage 1 resolves the lower half and both upper-half
// candidates; stage 2 selects the upper half by the mid carry and forms flags.
// Ports:
//   clk        1      rising-edge clock
//   rst        1      asynchronous active-low reset
//   in_valid   1      operands valid
//   in_ready   1      operands accepted this cycle (combinational on out_ready)
//   a, b       WIDTH  minuend, subtrahend
//   bin        1      borrow in
//   out_valid  1      result valid
//   out_ready  1      consumer accepts result
//   diff       WIDTH  a - b - bin mod 2^WIDTH
//   bout       1      unsigned borrow out
//   ovf        1      two's-complement overflow
//   zero       1      diff == 0
// WIDTH must be a multiple of 2*BLOCK.
// -----------------------------------------------------------------------------
module csel_subtractor_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int BLOCK = CSEL_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF   = WIDTH / 2;
  localparam int NSLICE = HALF / BLOCK;

  typedef struct packed {
    logic [HALF-1:0] lo;
    logic            cmid;
    logic [HALF-1:0] hi0;
    logic [HALF-1:0] hi1;
    logic            co0;
    logic            co1;
    logic            amsb;
    logic            bmsb;
  } s1_t;

  logic [WIDTH-1:0] nb_s;
  logic [HALF-1:0]  lo_sum_s;
  logic [HALF-1:0]  hi0_sum_s;
  logic [HALF-1:0]  hi1_sum_s;
  logic             lo_cmid_s;
  logic             hi_co0_s;
  logic             hi_co1_s;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             accept_s;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [HALF-1:0]  hi_sel_s;
  logic             co_sel_s;
  logic [WIDTH-1:0] diff_sel_s;

  // Subtraction as addition: invert b here; ~bin becomes the lowest carry-in.
  assign nb_s = ~b;

  // Lower half: plain carry-select ripple seeded with ~bin.
  for (genvar i = 0; i < NSLICE; i++) begin : g_lo
    logic             cin_s;
    logic             cout_s;
    logic [BLOCK-1:0] s0_unused_s;
    logic [BLOCK-1:0] s1_unused_s;
    logic             c0_unused_s;
    logic             c1_unused_s;

    if (i == 0) begin : g_first
      assign cin_s = ~bin;
    end else begin : g_rest
      assign cin_s = g_lo[i-1].cout_s;
    end

    csel_sub_slice #(.BLOCK(BLOCK)) u_slice (
      .a_i    (a[i*BLOCK +: BLOCK]),
      .nb_i   (nb_s[i*BLOCK +: BLOCK]),
      .cin_i  (cin_s),
      .sum0_o (s0_unused_s),
      .sum1_o (s1_unused_s),
      .cout0_o(c0_unused_s),
      .cout1_o(c1_unused_s),
      .sum_o  (lo_sum_s[i*BLOCK +: BLOCK]),
      .cout_o (cout_s)
    );
  end

  assign lo_cmid_s = g_lo[NSLICE-1].cout_s;

  // Upper half: the slice mux chain resolves the carry-in-0 hypothesis, and a
  // second select chain over the same slice candidates resolves carry-in 1.
  for (genvar i = 0; i < NSLICE; i++) begin : g_hi
    logic             cin0_s;
    logic             cout0_s;
    logic             c1_in_s;
    logic             c1_out_s;
    logic [BLOCK-1:0] cand0_s;
    logic [BLOCK-1:0] cand1_s;
    logic             cand_co0_s;
    logic             cand_co1_s;

    if (i == 0) begin : g_first
      assign cin0_s  = 1'b0;
      assign c1_in_s = 1'b1;
    end else begin : g_rest
      assign cin0_s  = g_hi[i-1].cout0_s;
      assign c1_in_s = g_hi[i-1].c1_out_s;
    end

    csel_sub_slice #(.BLOCK(BLOCK)) u_slice (
      .a_i    (a[HALF + i*BLOCK +: BLOCK]),
      .nb_i   (nb_s[HALF + i*BLOCK +: BLOCK]),
      .cin_i  (cin0_s),
      .sum0_o (cand0_s),
      .sum1_o (cand1_s),
      .cout0_o(cand_co0_s),
      .cout1_o(cand_co1_s),
      .sum_o  (hi0_sum_s[i*BLOCK +: BLOCK]),
      .cout_o (cout0_s)
    );

    assign hi1_sum_s[i*BLOCK +: BLOCK] = c1_in_s ? cand1_s : cand0_s;
    assign c1_out_s                    = c1_in_s ? cand_co1_s : cand_co0_s;
  end

  assign hi_co0_s = g_hi[NSLICE-1].cout0_s;
  assign hi_co1_s = g_hi[NSLICE-1].c1_out_s;

  // Handshake: a stage may load when it is empty or its contents move on.
  // in_ready is therefore combinational from out_ready.
  assign s2_adv_s = !s2_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  assign in_ready = s1_adv_s;
  assign accept_s = in_valid && s1_adv_s;

  // Stage 1 next state: capture lower result and both upper candidates on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      s1_d.lo   = lo_sum_s;
      s1_d.cmid = lo_cmid_s;
      s1_d.hi0  = hi0_sum_s;
      s1_d.hi1  = hi1_sum_s;
      s1_d.co0  = hi_co0_s;
      s1_d.co1  = hi_co1_s;
      s1_d.amsb = a[WIDTH-1];
      s1_d.bmsb = b[WIDTH-1];
    end else begin
      s1_d = s1_q;
    end
  end

  // Stage 2 select: zero is taken from the selected value, not the register.
  always_comb begin
    hi_sel_s   = s1_q.cmid ? s1_q.hi1 : s1_q.hi0;
    co_sel_s   = s1_q.cmid ? s1_q.co1 : s1_q.co0;
    diff_sel_s = {hi_sel_s, s1_q.lo};
  end

  // Stage 2 next state: result registers load only when a valid S1 entry moves.
  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_adv_s && s1_valid_q) begin
      diff_d = diff_sel_s;
      bout_d = ~co_sel_s;
      ovf_d  = csel_sub_ovf(s1_q.amsb, s1_q.bmsb, hi_sel_s[HALF-1]);
      zero_d = ~|diff_sel_s;
    end else begin
      diff_d = diff_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
    end
  end

  // Pipeline state registers; reset drops all in-flight operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// tb_csel_subtractor_pipe
// Directed checks of csel_subtractor_pipe (64-bit, 8-bit slices): reset state,
// latency, wrap-around, half-boundary borrow, signed overflow, a backpressured
// random stream against a reference model, and reset with operands in flight.
// -----------------------------------------------------------------------------
module tb_csel_subtractor_pipe;
  import csel_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_checks;
  int n_fails;

  csel_subtractor_pipe #(.WIDTH(64), .BLOCK(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .zero     (zero)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic csel_result_t ref_model(input logic [63:0] x, input logic [63:0] y,
                                             input logic bi);
    logic [64:0]  t;
    csel_result_t r;
    t      = {1'b0, x} - {1'b0, y} - {64'd0, bi};
    r.diff = t[63:0];
    r.bout = t[64];
    r.ovf  = (x[63] != y[63]) && (t[63] != x[63]);
    r.zero = (t[63:0] == 64'd0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one operand set with out_ready high and check the result two edges later.
  task automatic run_vec(input string tag, input logic [63:0] va, input logic [63:0] vb,
                         input logic vbin, input logic [63:0] ed, input logic eb,
                         input logic eo, input logic ez);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    bin      = vbin;
    #1;
    check_value({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_value({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
    step();
    check_value({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check_value({tag, ".diff"}, diff, ed);
    check_value({tag, ".bout"}, 64'(bout), 64'(eb));
    check_value({tag, ".ovf"}, 64'(ovf), 64'(eo));
    check_value({tag, ".zero"}, 64'(zero), 64'(ez));
  endtask

  initial begin
    csel_result_t q[$];
    csel_result_t er;
    logic [63:0]  na;
    logic [63:0]  nb;
    logic         nbin;
    logic         stalled;
    logic [63:0]  held_diff;
    int           sent;
    int           rcvd;

    n_checks  = 0;
    n_fails   = 0;
    clk       = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 64'd0;
    b         = 64'd0;
    bin       = 1'b0;

    // Reset state.
    #12;
    check_value("rst.out_valid", 64'(out_valid), 64'd0);
    check_value("rst.diff", diff, 64'd0);
    check_value("rst.flags", {61'd0, bout, ovf, zero}, 64'd0);
    step();
    rst = 1'b1;
    step();
    check_value("rst.in_ready", 64'(in_ready), 64'd1);

    // Directed vectors.
    run_vec("basic", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    run_vec("wrap", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_vec("equal", 64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    run_vec("half_borrow", 64'h0000_0001_0000_0000, 64'd0, 1'b1,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_vec("no_mid_borrow", 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0001, 1'b0,
            64'h1234_5677_9ABC_DEEF, 1'b0, 1'b0, 1'b0);
    run_vec("bin_wrap", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_vec("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_vec("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    step();

    // Backpressured random stream; q holds results for operands inside the pipe.
    sent      = 0;
    rcvd      = 0;
    stalled   = 1'b0;
    held_diff = 64'd0;
    na        = {$urandom, $urandom};
    nb        = {$urandom, $urandom};
    nbin      = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      a         = na;
      b         = nb;
      bin       = nbin;
      #1;
      check_value("bp.in_ready", 64'(in_ready),
                  (q.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
      check_value("bp.orphan_valid", 64'(out_valid && q.size() == 0), 64'd0);
      if (stalled) begin
        check_value("bp.stall_valid", 64'(out_valid), 64'd1);
        check_value("bp.stall_diff", diff, held_diff);
      end
      if (out_valid && q.size() > 0) begin
        er = q[0];
        check_value("bp.diff", diff, er.diff);
        check_value("bp.flags", {61'd0, bout, ovf, zero}, {61'd0, er.bout, er.ovf, er.zero});
      end
      stalled   = out_valid && !out_ready;
      held_diff = diff;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(na, nb, nbin));
        sent++;
        na   = {$urandom, $urandom};
        nb   = {$urandom, $urandom};
        nbin = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_value("bp.received", 64'(rcvd), 64'd10);
    check_value("bp.leftover", 64'(q.size()), 64'd0);

    // Reset with two operands in flight.
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    a        = 64'd100;
    b        = 64'd1;
    bin      = 1'b0;
    step();
    a        = 64'd50;
    b        = 64'd2;
    step();
    in_valid = 1'b0;
    check_value("mid.inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_value("mid.rst_valid", 64'(out_valid), 64'd0);
    check_value("mid.rst_diff", diff, 64'd0);
    check_value("mid.rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_value("mid.no_stale", 64'(out_valid), 64'd0);
    end
    run_vec("post_rst", 64'h10, 64'h8, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
